// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU interrupt path.
package cpu_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQUEST,
        IRQ_SERVICE
    } irq_state_t;

    localparam int IRQ_VECTOR_W = 16;

    // Handler entry address; all arithmetic stays in 16 bits and wraps.
    function automatic logic [IRQ_VECTOR_W-1:0] irq_vector_addr(
        input logic [IRQ_VECTOR_W-1:0] base,
        input logic [IRQ_VECTOR_W-1:0] stride,
        input logic [IRQ_VECTOR_W-1:0] idx
    );
        return base + stride * idx;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: the lowest set bit wins. Returns the one-hot winner, its index and a valid flag.
module irq_priority_enc #(
    parameter int W     = 4,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     req,
    output logic [W-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one to overwrite.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches IRQ lines into pending, masks them, grants the lowest-index
// unmasked request and sequences it through REQUEST -> SERVICE -> IDLE using the CPU FSM strobes.
// Build option: IRQ_EDGE_DETECT_EN selects rising-edge capture; otherwise lines are level-sensitive.
//
// Handshake with the CPU FSM: a nonzero 'interrupt' is a valid request that stays stable until
// the FSM answers with save_state (accept); the grant then stays up through SERVICE until
// restore_state (return). Strobes arriving in any other state are ignored and set 'spurious'.
module interrupt_controller
    import cpu_pkg::*;
#(
    parameter int                       INTERRUPT_WIDTH = 4,
    parameter logic [IRQ_VECTOR_W-1:0]  VECTOR_BASE     = 16'h0,
    parameter int                       VECTOR_STRIDE   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INTERRUPT_WIDTH-1:0]  irq_in,
    input  logic                        mask_wr,
    input  logic [INTERRUPT_WIDTH-1:0]  mask_data,
    input  logic                        save_state,
    input  logic                        restore_state,
    output logic [INTERRUPT_WIDTH-1:0]  interrupt,
    output logic [IRQ_VECTOR_W-1:0]     vector,
    output logic [INTERRUPT_WIDTH-1:0]  irq_mask,
    output logic [INTERRUPT_WIDTH-1:0]  pending,
    output logic                        busy,
    output logic                        spurious,
    output irq_state_t                  state_dbg
);

    localparam int IDX_W = (INTERRUPT_WIDTH > 1) ? $clog2(INTERRUPT_WIDTH) : 1;

    irq_state_t                 state, state_nxt;
    logic [INTERRUPT_WIDTH-1:0] unmasked;
    logic [INTERRUPT_WIDTH-1:0] enc_onehot;
    logic [IDX_W-1:0]           enc_idx;
    logic                       enc_valid;
    logic [INTERRUPT_WIDTH-1:0] set_mask;
    logic [INTERRUPT_WIDTH-1:0] clr_mask;
    logic                       grant_load;
    logic                       accept;
    logic                       release_grant;
    logic                       bad_strobe;

`ifdef IRQ_EDGE_DETECT_EN
    logic [INTERRUPT_WIDTH-1:0] irq_prev;

    // Previous line levels for rising-edge detection; zero out of reset so a high line counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_prev <= '0;
        else     irq_prev <= irq_in;
    end

    assign set_mask = irq_in & ~irq_prev;
`else
    assign set_mask = irq_in;
`endif

    assign unmasked = pending & irq_mask;

    irq_priority_enc #(
        .W     (INTERRUPT_WIDTH),
        .IDX_W (IDX_W)
    ) u_prio (
        .req    (unmasked),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    assign grant_load    = (state == IRQ_IDLE) && enc_valid;
    assign accept        = (state == IRQ_REQUEST) && save_state;
    assign release_grant = (state == IRQ_SERVICE) && restore_state;
    assign bad_strobe    = (save_state && (state != IRQ_REQUEST)) ||
                           (restore_state && (state != IRQ_SERVICE));
    assign clr_mask      = accept ? interrupt : '0;
    assign busy          = (state == IRQ_SERVICE);
    assign state_dbg     = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IRQ_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: grant from IDLE, accept on save_state, return on restore_state.
    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_IDLE:    if (enc_valid)     state_nxt = IRQ_REQUEST;
            IRQ_REQUEST: if (save_state)    state_nxt = IRQ_SERVICE;
            IRQ_SERVICE: if (restore_state) state_nxt = IRQ_IDLE;
            default:                        state_nxt = IRQ_IDLE;
        endcase
    end

    // Grant and vector are captured once in IDLE and held until the return strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interrupt <= '0;
            vector    <= '0;
        end else if (grant_load) begin
            interrupt <= enc_onehot;
            vector    <= irq_vector_addr(VECTOR_BASE, IRQ_VECTOR_W'(VECTOR_STRIDE),
                                         IRQ_VECTOR_W'(enc_idx));
        end else if (release_grant) begin
            interrupt <= '0;
            vector    <= '0;
        end
    end

    // Pending requests: a new request wins over the accept-cycle clear of the same line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr_mask) | set_mask;
    end

    // Software mask; all lines enabled out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          irq_mask <= '1;
        else if (mask_wr) irq_mask <= mask_data;
    end

    // Sticky flag for strobes that do not match the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             spurious <= 1'b0;
        else if (bad_strobe) spurious <= 1'b1;
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller (W=4, base 0, stride 7). Honours IRQ_EDGE_DETECT_EN.
module tb_interrupt_controller;
    import cpu_pkg::*;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  irq_in;
    logic          mask_wr;
    logic [W-1:0]  mask_data;
    logic          save_state;
    logic          restore_state;
    logic [W-1:0]  interrupt;
    logic [15:0]   vector;
    logic [W-1:0]  irq_mask;
    logic [W-1:0]  pending;
    logic          busy;
    logic          spurious;
    irq_state_t    state_dbg;

    logic [W+15:0] exp_q[$];
    logic [W+15:0] exp_w;
    logic [W-1:0]  prev_int;
    int            checks = 0;
    int            errors = 0;

    interrupt_controller #(
        .INTERRUPT_WIDTH (W),
        .VECTOR_BASE     (16'h0),
        .VECTOR_STRIDE   (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .mask_wr       (mask_wr),
        .mask_data     (mask_data),
        .save_state    (save_state),
        .restore_state (restore_state),
        .interrupt     (interrupt),
        .vector        (vector),
        .irq_mask      (irq_mask),
        .pending       (pending),
        .busy          (busy),
        .spurious      (spurious),
        .state_dbg     (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_grant(input logic [W-1:0] g, input logic [15:0] v);
        exp_q.push_back({g, v});
    endtask

    task automatic do_save();
        save_state = 1'b1;
        step(1);
        save_state = 1'b0;
    endtask

    task automatic do_restore();
        restore_state = 1'b1;
        step(1);
        restore_state = 1'b0;
    endtask

    // Scoreboard: every new grant must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_int = '0;
        end else begin
            if (interrupt != '0 && prev_int == '0) begin
                check("grant_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("grant_vec", 32'({interrupt, vector}), 32'(exp_w));
                end
            end
            prev_int = interrupt;
        end
    end

    initial begin
        rst = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
        save_state = 1'b0; restore_state = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_int",     32'(interrupt), 32'(0));
        check("rst_mask",    32'(irq_mask),  32'(4'hF));
        check("rst_pending", 32'(pending),   32'(0));
        check("rst_state",   32'(state_dbg), 32'(IRQ_IDLE));

        // Two lines at once: line 1 first, line 2 after return.
        irq_in = 4'b0110;
        expect_grant(4'b0010, 16'd7);
        expect_grant(4'b0100, 16'd14);
        step(1);
        irq_in = '0;
        check("t2_pend0",  32'(pending),   32'(4'b0110));
        check("t2_int0",   32'(interrupt), 32'(0));
        step(1);
        check("t2_int1",   32'(interrupt), 32'(4'b0010));
        check("t2_vec1",   32'(vector),    32'(7));
        check("t2_req",    32'(state_dbg), 32'(IRQ_REQUEST));
        do_save();
        check("t2_pend1",  32'(pending),   32'(4'b0100));
        check("t2_busy",   32'(busy),      32'(1));
        check("t2_hold",   32'(interrupt), 32'(4'b0010));
        do_restore();
        check("t2_int_r",  32'(interrupt), 32'(0));
        check("t2_vec_r",  32'(vector),    32'(0));
        check("t2_busy_r", 32'(busy),      32'(0));
        step(1);
        check("t2_int2",   32'(interrupt), 32'(4'b0100));
        check("t2_vec2",   32'(vector),    32'(14));
        do_save();
        do_restore();
        check("t2_pend_e", 32'(pending),   32'(0));
        check("t2_idle",   32'(state_dbg), 32'(IRQ_IDLE));

        // Masked line latches but is not granted until unmasked.
        mask_wr = 1'b1; mask_data = 4'b1110;
        step(1);
        mask_wr = 1'b0;
        check("t3_mask",   32'(irq_mask),  32'(4'b1110));
        irq_in = 4'b0001;
        step(1);
        irq_in = '0;
        check("t3_pend",   32'(pending),   32'(4'b0001));
        step(2);
        check("t3_masked", 32'(interrupt), 32'(0));
        expect_grant(4'b0001, 16'd0);
        mask_wr = 1'b1; mask_data = 4'hF;
        step(1);
        mask_wr = 1'b0;
        check("t3_int_n",  32'(interrupt), 32'(0));
        step(1);
        check("t3_int",    32'(interrupt), 32'(4'b0001));
        check("t3_vec",    32'(vector),    32'(0));
        do_save();
        do_restore();

        // Strobes in the wrong state.
        check("t4_spur0",  32'(spurious),  32'(0));
        do_restore();
        check("t4_spur1",  32'(spurious),  32'(1));
        check("t4_idle",   32'(state_dbg), 32'(IRQ_IDLE));
        irq_in = 4'b1000;
        expect_grant(4'b1000, 16'd21);
        step(1);
        irq_in = '0;
        step(1);
        do_save();
        do_save();
        check("t4_svc",    32'(state_dbg), 32'(IRQ_SERVICE));
        check("t4_hold",   32'(interrupt), 32'(4'b1000));
        save_state = 1'b1; restore_state = 1'b1;
        step(1);
        save_state = 1'b0; restore_state = 1'b0;
        check("t4_both",   32'(state_dbg), 32'(IRQ_IDLE));
        check("t4_spur2",  32'(spurious),  32'(1));

        // Re-request on the granted line during the accept cycle.
        irq_in = 4'b1000;
        expect_grant(4'b1000, 16'd21);
        step(1);
        irq_in = '0;
        step(1);
        irq_in = 4'b1000;
        expect_grant(4'b1000, 16'd21);
        do_save();
        irq_in = '0;
        check("t5_pend",   32'(pending),   32'(4'b1000));
        check("t5_svc",    32'(state_dbg), 32'(IRQ_SERVICE));
        do_restore();
        step(1);
        check("t5_int",    32'(interrupt), 32'(4'b1000));
        check("t5_vec",    32'(vector),    32'(21));
        do_save();
        do_restore();

        // Line 0 held high for 10 cycles.
        irq_in = 4'b0001;
        expect_grant(4'b0001, 16'd0);
`ifndef IRQ_EDGE_DETECT_EN
        expect_grant(4'b0001, 16'd0);
`endif
        step(2);
        check("t6_int1",   32'(interrupt), 32'(4'b0001));
        do_save();
`ifdef IRQ_EDGE_DETECT_EN
        check("t6_pend",   32'(pending),   32'(0));
`else
        check("t6_pend",   32'(pending),   32'(4'b0001));
`endif
        do_restore();
        step(1);
`ifdef IRQ_EDGE_DETECT_EN
        check("t6_int2",   32'(interrupt), 32'(0));
`else
        check("t6_int2",   32'(interrupt), 32'(4'b0001));
`endif
        step(5);
        irq_in = '0;
`ifndef IRQ_EDGE_DETECT_EN
        do_save();
        do_restore();
`else
        step(2);
`endif
        check("t6_pend_e", 32'(pending),   32'(0));
        check("t6_idle",   32'(state_dbg), 32'(IRQ_IDLE));

        // Asynchronous reset while servicing line 1.
        irq_in = 4'b0010;
        expect_grant(4'b0010, 16'd7);
        step(1);
        irq_in = '0;
        step(1);
        do_save();
        check("t1_busy",   32'(busy),      32'(1));
        rst = 1'b1;
        #1;
        check("t1_int",    32'(interrupt), 32'(0));
        check("t1_vec",    32'(vector),    32'(0));
        check("t1_pend",   32'(pending),   32'(0));
        check("t1_spur",   32'(spurious),  32'(0));
        check("t1_mask",   32'(irq_mask),  32'(4'hF));
        check("t1_busy0",  32'(busy),      32'(0));
        check("t1_state",  32'(state_dbg), 32'(IRQ_IDLE));
        step(1);
        rst = 1'b0;
        step(3);
        check("t1_quiet",  32'(interrupt), 32'(0));

        check("exp_q_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
